// File: rtl/tx_sched_pkg.sv
// rtl/tx_sched_pkg.sv - shared state encodings, requester indices and helpers for the tx scheduler
package tx_sched_pkg;

  // Default message width: 16 ASCII characters.
  localparam int MSG_W_DEFAULT = 128;

  // Requester indices on the req / req_msg / grant vectors.
  localparam logic [1:0] REQ_KBD   = 2'd0;
  localparam logic [1:0] REQ_SMILE = 2'd1;
  localparam logic [1:0] REQ_FROWN = 2'd2;
  localparam logic [1:0] REQ_TEXT  = 2'd3;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    SEND         = 2'd1,
    RETRY_GAP    = 2'd2,
    WAIT_RELEASE = 2'd3
  } tx_state_e;

  // Round-robin pointer moves just past the requester that was served or abandoned.
  function automatic logic [1:0] ptr_after(input logic [1:0] idx);
    return idx + 2'd1;
  endfunction

endpackage

// File: rtl/tx_message_scheduler_rr_pick4.sv
// rtl/tx_message_scheduler_rr_pick4.sv - combinational 4-way round-robin picker
module rr_pick4 (
  input  logic [3:0] pending,
  input  logic [1:0] ptr,
  output logic       valid,
  output logic [1:0] idx
);

  logic [1:0] cand;

  // Scan from ptr upward with 2-bit wrap; the first pending index found wins.
  always_comb begin
    valid = 1'b0;
    idx   = ptr;
    cand  = ptr;
    for (int k = 0; k < 4; k++) begin
      cand = ptr + 2'(k);
      if (!valid && pending[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/tx_message_scheduler.sv
// rtl/tx_message_scheduler.sv - round-robin sequencer of four message sources onto one gpio transmit channel
module tx_message_scheduler
  import tx_sched_pkg::*;
#(
  parameter int MSG_W       = MSG_W_DEFAULT,
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 50000000,
  parameter int RETRY_MAX   = 3
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*MSG_W-1:0] req_msg,
  output logic                     tx_data_ready,
  output logic [MSG_W-1:0]         tx_message,
  input  logic                     tx_done,
  output logic [NUM_REQ-1:0]       grant,
  output logic                     tx_busy,
  output logic                     tx_error,
  output logic [1:0]               attempt
);

  // The counter runs 0 .. TIMEOUT_CYC-1 inside one SEND window and is cleared
  // on every exit from SEND, so it never needs to hold TIMEOUT_CYC itself.
  localparam int               CNT_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [1:0]       ATT_MAX  = 2'(RETRY_MAX);

  tx_state_e          state_q, state_d;
  logic [NUM_REQ-1:0] req_q;
  logic [NUM_REQ-1:0] pend_q, pend_d;
  logic [1:0]         ptr_q, ptr_d;
  logic [1:0]         win_q, win_d;
  logic [MSG_W-1:0]   msg_q, msg_d;
  logic               ready_q, ready_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               err_q, err_d;
  logic [1:0]         attempt_q, attempt_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [NUM_REQ-1:0] req_rise;
  logic [NUM_REQ-1:0] pend_clr;
  logic               pick_valid;
  logic [1:0]         pick_idx;
  logic [MSG_W-1:0]   msg_sel;

  assign req_rise = req & ~req_q;

  rr_pick4 u_pick (
    .pending (pend_q),
    .ptr     (ptr_q),
    .valid   (pick_valid),
    .idx     (pick_idx)
  );

  // Select the candidate winner's message so it can be latched at transfer start.
  always_comb begin
    msg_sel = req_msg[3*MSG_W +: MSG_W];
    case (pick_idx)
      REQ_KBD:   msg_sel = req_msg[0*MSG_W +: MSG_W];
      REQ_SMILE: msg_sel = req_msg[1*MSG_W +: MSG_W];
      REQ_FROWN: msg_sel = req_msg[2*MSG_W +: MSG_W];
      REQ_TEXT:  msg_sel = req_msg[3*MSG_W +: MSG_W];
      default:   msg_sel = req_msg[3*MSG_W +: MSG_W];
    endcase
  end

  // Transfer FSM: start, timeout/retry, completion and release handshake.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    win_d     = win_q;
    msg_d     = msg_q;
    ready_d   = ready_q;
    grant_d   = '0;
    err_d     = 1'b0;
    attempt_d = attempt_q;
    cnt_d     = cnt_q;
    pend_clr  = '0;

    case (state_q)
      IDLE: begin
        // A done level left over from the previous transfer must not be
        // mistaken for completion of the next one, so wait for it to drop.
        if (pick_valid && !tx_done) begin
          win_d     = pick_idx;
          msg_d     = msg_sel;
          ready_d   = 1'b1;
          attempt_d = 2'd0;
          cnt_d     = '0;
          state_d   = SEND;
        end
      end

      SEND: begin
        if (tx_done) begin
          ready_d  = 1'b0;
          grant_d  = NUM_REQ'(1) << win_q;
          pend_clr = NUM_REQ'(1) << win_q;
          ptr_d    = ptr_after(win_q);
          cnt_d    = '0;
          state_d  = WAIT_RELEASE;
        end else if (cnt_q == CNT_LAST) begin
          ready_d = 1'b0;
          cnt_d   = '0;
          if (attempt_q < ATT_MAX) begin
            attempt_d = attempt_q + 2'd1;
            state_d   = RETRY_GAP;
          end else begin
            err_d    = 1'b1;
            pend_clr = NUM_REQ'(1) << win_q;
            ptr_d    = ptr_after(win_q);
            state_d  = WAIT_RELEASE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      RETRY_GAP: begin
        // One low cycle so gpio_protocol sees a fresh rising edge of ready.
        ready_d = 1'b1;
        state_d = SEND;
      end

      WAIT_RELEASE: begin
        if (!tx_done) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    // A new edge landing on the same cycle as the clear is kept.
    pend_d = (pend_q & ~pend_clr) | req_rise;
  end

  // State, pending flags and all registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      req_q     <= '0;
      pend_q    <= '0;
      ptr_q     <= 2'd0;
      win_q     <= 2'd0;
      msg_q     <= '0;
      ready_q   <= 1'b0;
      grant_q   <= '0;
      err_q     <= 1'b0;
      attempt_q <= 2'd0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req;
      pend_q    <= pend_d;
      ptr_q     <= ptr_d;
      win_q     <= win_d;
      msg_q     <= msg_d;
      ready_q   <= ready_d;
      grant_q   <= grant_d;
      err_q     <= err_d;
      attempt_q <= attempt_d;
      cnt_q     <= cnt_d;
    end
  end

  assign tx_data_ready = ready_q;
  assign tx_message    = msg_q;
  assign grant         = grant_q;
  assign tx_error      = err_q;
  assign attempt       = attempt_q;
  assign tx_busy       = (state_q != IDLE);

endmodule

// File: doc/tx_message_scheduler.md
Name: tx_message_scheduler

Overview:
Sequences the single GPIO transmit channel (gpio_protocol data_ready/done handshake) between four message sources: keyboard-composed LCD text, smiley preset, frown preset and canned text preset. Replaces the ad-hoc switch-edge latching and combinational message_out mux in the top level. Each request is captured as a pending flag, arbitrated round-robin, and its 128-bit message is held stable for the whole transfer. A stalled transfer is retried after a timeout.

Parameters:
MSG_W, 128, message width in bits (16 ASCII characters).
NUM_REQ, 4, number of requesters; fixed at 4.
TIMEOUT_CYC, 50000000, SEND cycles without done before a retry (1 s at 50 MHz).
RETRY_MAX, 3, retries after the first attempt before the request is abandoned.

Ports:
clock  in  1  system clock (CLOCK_50 domain).
reset  in  1  synchronous, active-high reset.
req  in  4  level request lines. A rising edge registers a request. Index 0 = keyboard, 1 = smiley, 2 = frown, 3 = preset text.
req_msg  in  4*MSG_W  messages, packed; requester i occupies bits [i*MSG_W +: MSG_W].
tx_data_ready  out  1  to gpio_protocol data_ready.
tx_message  out  MSG_W  to gpio_protocol message_out.
tx_done  in  1  from gpio_protocol done (level).
grant  out  4  one-hot, 1-cycle pulse when the requester's transfer completes.
tx_busy  out  1  high in any state other than IDLE.
tx_error  out  1  1-cycle pulse when a request is abandoned.
attempt  out  2  current attempt index (0..RETRY_MAX).

Behaviour:
- Reset values:
  - All outputs 0; tx_message = 0.
  - pending = 0, req_q = 0.
  - Round-robin pointer = 0; state = IDLE; timeout counter = 0.
- Edge capture:
  - req_q <= req each cycle.
  - pending[i] is set on the cycle after req[i] & ~req_q[i].
  - If a set and a clear of the same bit land on the same cycle, the set wins (the new request is kept).
- States: IDLE, SEND, RETRY_GAP, WAIT_RELEASE.
- IDLE:
  - Starts only when pending != 0 and tx_done == 0.
  - Choose the first pending index at or after the pointer, wrapping 3 -> 0.
  - Latch req_msg for the winner into tx_message and store the winner index.
  - Set tx_data_ready = 1, attempt = 0, counter = 0, and go to SEND.
  - Latency: req edge at cycle N, pending at N+1, tx_data_ready high at N+2.
- SEND:
  - tx_message stays frozen even if req_msg changes.
  - On tx_done = 1:
    - tx_data_ready <= 0 and grant[winner] pulses.
    - pending[winner] clears; pointer <= winner + 1 (mod 4).
    - Go to WAIT_RELEASE.
  - Otherwise the counter increments. When it reaches TIMEOUT_CYC - 1:
    - If attempt < RETRY_MAX: tx_data_ready <= 0, attempt++, counter <= 0, go to RETRY_GAP.
    - Else: tx_data_ready <= 0, tx_error pulses, pending[winner] clears, pointer <= winner + 1, go to WAIT_RELEASE.
- RETRY_GAP: exactly one cycle with ready low, then tx_data_ready <= 1 and back to SEND (gives gpio_protocol a fresh rising edge).
- WAIT_RELEASE: stay until tx_done == 0, then go to IDLE. No new request starts while done is still asserted.
- tx_done while in IDLE is ignored.
- Requests arriving during a transfer only set pending; they never preempt the current transfer.
- Reset mid-transfer: on the next edge tx_data_ready = 0, pending is dropped, and grant/tx_error do not pulse.
- Counter width: $clog2(TIMEOUT_CYC); no overflow, since it is cleared on every terminal condition.

Decomposition:
- Shared package tx_sched_pkg holds:
  - state encodings (IDLE = 2'd0, SEND = 2'd1, RETRY_GAP = 2'd2, WAIT_RELEASE = 2'd3);
  - requester index constants (REQ_KBD = 0, REQ_SMILE = 1, REQ_FROWN = 2, REQ_TEXT = 3);
  - MSG_W default.
- One sub-module: rr_pick4, a combinational 4-way round-robin picker.
  - Inputs: pending[3:0], ptr[1:0].
  - Outputs: valid, idx[1:0].
  - It is tested standalone; the FSM, counter and message latch stay in tx_message_scheduler.

Test Plan:
- Single request: req[1] rises at cycle 10, tx_done asserted at cycle 20 and dropped at 25.
  - tx_data_ready = 1 from cycle 12.
  - tx_message = req_msg[255:128].
  - grant = 4'b0010 for one cycle at 21.
  - tx_busy = 0 from cycle 26.
- Round-robin: req[0] and req[3] rise together, pointer = 0.
  - Index 0 is served first, then index 3.
  - Next, simultaneous req[0] and req[2] serve 0 before 2 (pointer = 0 after 3 wraps), then 2.
- Message freeze: during SEND for index 0, req_msg[127:0] changes from "hi" to "bye".
  - tx_message stays "hi" until grant.
- Timeout/retry (TIMEOUT_CYC = 8, RETRY_MAX = 3, tx_done never asserted):
  - tx_data_ready drops for 1 cycle after each 8-cycle SEND window.
  - attempt steps 0 -> 1 -> 2 -> 3.
  - tx_error pulses after the 4th window; pending clears.
- Simultaneous events: req[2] re-rises on the same cycle its pending bit clears on grant.
  - pending[2] stays 1 and a second transfer of index 2 follows.
  - tx_done held high through IDLE delays the start until it falls.
- Reset mid-SEND: reset = 1 for 1 cycle.
  - Next cycle tx_data_ready = 0, tx_busy = 0, pending = 0.
  - No grant or tx_error pulse.
